// File: rtl/regfile_write_arbiter.sv
// Two-requester write arbiter (core, APB) for the register file; APB always writes reg 7.
// Define REGFILE_ARB_RR_EN for round-robin arbitration, otherwise APB has fixed priority.
module regfile_write_arbiter #(
    parameter int WR_SETTLE = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       core_req,
    input  logic [2:0] core_addr,
    input  logic [7:0] core_data,
    output logic       core_ack,
    input  logic       apb_req,
    input  logic [7:0] apb_wdata,
    output logic       apb_ack,
    output logic       reg_write_en,
    output logic [2:0] reg_write_addr,
    output logic [7:0] reg_write_data,
    output logic       apb_op,
    output logic [7:0] apb_data,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        ACK,
        SETTLE
    } state_t;

    localparam logic [1:0] SETTLE_LAST =
        (WR_SETTLE > 0) ? 2'(WR_SETTLE - 1) : 2'd0;

    state_t     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic       win_apb_q, win_apb_d;
    logic       we_d, op_d, cack_d, aack_d, busy_d;
    logic [2:0] addr_d;
    logic [7:0] data_d, apbd_d;
    logic       grant, pick_apb;

    assign grant = (state_q == IDLE) && (core_req || apb_req);

`ifdef REGFILE_ARB_RR_EN
    logic last_apb_q;

    // On a tie the requester that did not win last time is served.
    assign pick_apb = (core_req && apb_req) ? !last_apb_q : apb_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_apb_q <= 1'b1;
        end else if (grant) begin
            last_apb_q <= pick_apb;
        end
    end
`else
    assign pick_apb = apb_req;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        win_apb_d = win_apb_q;
        we_d      = 1'b0;
        op_d      = 1'b0;
        cack_d    = 1'b0;
        aack_d    = 1'b0;
        busy_d    = busy;
        addr_d    = reg_write_addr;
        data_d    = reg_write_data;
        apbd_d    = apb_data;
        unique case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d   = WRITE;
                    win_apb_d = pick_apb;
                    we_d      = 1'b1;
                    op_d      = pick_apb;
                    busy_d    = 1'b1;
                    if (pick_apb) begin
                        addr_d = 3'd7;
                        data_d = apb_wdata;
                        apbd_d = apb_wdata;
                    end else begin
                        addr_d = core_addr;
                        data_d = core_data;
                    end
                end
            end
            WRITE: begin
                state_d = ACK;
                cack_d  = !win_apb_q;
                aack_d  = win_apb_q;
            end
            ACK: begin
                if (WR_SETTLE > 0) begin
                    state_d = SETTLE;
                    cnt_d   = 2'd0;
                end else begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            cnt_q          <= 2'd0;
            win_apb_q      <= 1'b0;
            reg_write_en   <= 1'b0;
            apb_op         <= 1'b0;
            core_ack       <= 1'b0;
            apb_ack        <= 1'b0;
            busy           <= 1'b0;
            reg_write_addr <= 3'd0;
            reg_write_data <= 8'd0;
            apb_data       <= 8'd0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            win_apb_q      <= win_apb_d;
            reg_write_en   <= we_d;
            apb_op         <= op_d;
            core_ack       <= cack_d;
            apb_ack        <= aack_d;
            busy           <= busy_d;
            reg_write_addr <= addr_d;
            reg_write_data <= data_d;
            apb_data       <= apbd_d;
        end
    end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 SHALL have parameter: WR_SETTLE, default 0, idle cycles inserted after each completed write (legal 0..3).
REQ-002 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: core_req  input  1  core write request, level, held until core_ack.
REQ-005 SHALL have port: core_addr  input  3  core target register index.
REQ-006 SHALL have port: core_data  input  8  core write data.
REQ-007 SHALL have port: core_ack  output  1  one-cycle pulse, core write completed.
REQ-008 SHALL have port: apb_req  input  1  APB write request, level, held until apb_ack.
REQ-009 SHALL have port: apb_wdata  input  8  APB write data, always targets register 7.
REQ-010 SHALL have port: apb_ack  output  1  one-cycle pulse, APB write completed.
REQ-011 SHALL have port: reg_write_en  output  1  write strobe to register file.
REQ-012 SHALL have port: reg_write_addr  output  3  register file write index.
REQ-013 SHALL have port: reg_write_data  output  8  register file write data.
REQ-014 SHALL have port: apb_op  output  1  register file APB-override select.
REQ-015 SHALL have port: apb_data  output  8  register file APB data.
REQ-016 SHALL have port: busy  output  1  high whenever state is not IDLE.

Function
REQ-017 SHALL implement FSM IDLE -> WRITE -> ACK -> (SETTLE if WR_SETTLE>0) -> IDLE; all outputs registered.
REQ-018 SHALL in IDLE, when any req is high at edge N, pick a winner, latch its addr/data into holding registers, enter WRITE.
REQ-019 SHALL in WRITE (cycle N+1) drive reg_write_en=1 for exactly one cycle with held addr/data; APB winner: apb_op=1, reg_write_addr=7, apb_data=reg_write_data=held data.
REQ-020 SHALL in ACK (cycle N+2) pulse the winner's ack for exactly one cycle; the loser's ack stays 0.
REQ-021 SHALL keep reg_write_en, apb_op, both acks at 0 outside WRITE/ACK respectively; addr/data outputs hold last value.
REQ-022 SHALL ignore core_req/apb_req outside IDLE; a requester must drop req in the cycle after its ack.
REQ-023 SHALL in SETTLE count WR_SETTLE cycles exactly, then return to IDLE.
REQ-024 SHALL ignore changes to addr/data inputs after the IDLE capture edge.
REQ-025 SHALL with a single requester always grant it regardless of arbitration history.
REQ-026 SHALL give a back-to-back request from the same requester a throughput of one write per 3+WR_SETTLE cycles.

Reset
REQ-027 SHALL on rst_n low immediately force state IDLE, reg_write_en=0, apb_op=0, core_ack=0, apb_ack=0, busy=0, reg_write_addr=0, reg_write_data=0, apb_data=0, settle counter 0, last-grant pointer = APB.
REQ-028 SHALL on reset during WRITE or ACK abort the transfer with no ack issued; requester must re-request.
REQ-029 SHALL evaluate requests no earlier than the first rising edge after rst_n deasserts.

Configuration
REQ-030 SHALL, with REGFILE_ARB_RR_EN defined, resolve simultaneous requests round-robin: the requester not granted last wins, pointer updates on each grant.
REQ-031 SHALL, without REGFILE_ARB_RR_EN, resolve simultaneous requests by fixed priority, APB always winning; no pointer state exists.

Verification
REQ-032 SHALL cover: core_req, core_addr=3, core_data=0xA5 at edge 0 -> reg_write_en=1, addr=3, data=0xA5, apb_op=0 at cycle 1; core_ack at cycle 2; busy high cycles 1-2.
REQ-033 SHALL cover: apb_req, apb_wdata=0x3C -> cycle 1 reg_write_en=1, apb_op=1, reg_write_addr=7, apb_data=0x3C; apb_ack at cycle 2.
REQ-034 SHALL cover: both req held continuously from reset release, RR_EN defined -> grant order core, APB, core, APB; undefined -> APB every grant, core never acked.
REQ-035 SHALL cover: WR_SETTLE=2, core_req held across two writes -> second reg_write_en 5 cycles after first.
REQ-036 SHALL cover: rst_n low during WRITE cycle -> all outputs 0 asynchronously, no ack, next request after release served normally.
